// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 default raster constants and counter-width helper
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
    localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

    function automatic int cnt_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing bundle from the timing generator to the pixel drawer
interface vga_timing_if;

    logic        pix_ce;
    logic [9:0]  CounterX;
    logic [9:0]  CounterY;
    logic        inDisplayArea;
    logic        vga_h_sync;
    logic        vga_v_sync;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (
        output pix_ce, CounterX, CounterY, inDisplayArea, vga_h_sync, vga_v_sync,
               line_start, frame_start, frame_count
    );

    modport slave (
        input pix_ce, CounterX, CounterY, inDisplayArea, vga_h_sync, vga_v_sync,
              line_start, frame_start, frame_count
    );

endinterface

// File: rtl/pixel_ce_div.sv
// pixel_ce_div: registered one-clk enable pulse every PIX_DIV clocks
module pixel_ce_div
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic ce
);

    localparam int W = cnt_width(PIX_DIV);
    localparam logic [W-1:0] LAST = W'(PIX_DIV - 1);

    if (PIX_DIV < 1) begin : g_bad_div
        $error("pixel_ce_div: PIX_DIV must be >= 1");
    end

    logic [W-1:0] div_cnt;
    logic [W-1:0] div_nxt;

    assign div_nxt = (div_cnt == LAST) ? '0 : div_cnt + 1'b1;

    // ce is registered so it is high exactly while div_cnt sits at LAST
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            ce      <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            ce      <= div_nxt == LAST;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel enable, raster counters, display flag, syncs and line/frame strobes
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int PIX_DIV    = 2
) (
    input logic          clk,
    input logic          reset,
    vga_timing_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] Y_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    pixel_ce_div #(.PIX_DIV(PIX_DIV)) u_div (
        .clk   (clk),
        .reset (reset),
        .ce    (vga.pix_ce)
    );

    logic       adv;
    logic       x_wrap;
    logic       y_wrap;
    logic       ls_nxt;
    logic       fs_nxt;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;

    // with no division every non-reset clk is a pixel, including the first one after reset
    always_comb begin
        adv    = (PIX_DIV == 1) || vga.pix_ce;
        x_wrap = vga.CounterX == X_LAST;
        y_wrap = vga.CounterY == Y_LAST;
        ls_nxt = adv && x_wrap;
        fs_nxt = ls_nxt && y_wrap;
        x_nxt  = adv ? (x_wrap ? '0 : vga.CounterX + 10'd1) : vga.CounterX;
        y_nxt  = ls_nxt ? (y_wrap ? '0 : vga.CounterY + 10'd1) : vga.CounterY;
    end

    // decode from next-state counters so flags line up with the counters they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            vga.CounterX      <= X_LAST;
            vga.CounterY      <= Y_LAST;
            vga.inDisplayArea <= 1'b0;
            vga.vga_h_sync    <= ~H_SYNC_POL;
            vga.vga_v_sync    <= ~V_SYNC_POL;
            vga.line_start    <= 1'b0;
            vga.frame_start   <= 1'b0;
            vga.frame_count   <= '0;
        end else begin
            vga.CounterX      <= x_nxt;
            vga.CounterY      <= y_nxt;
            vga.inDisplayArea <= x_nxt < X_ACT && y_nxt < Y_ACT;
            vga.vga_h_sync    <= (x_nxt >= HS_BEG && x_nxt <= HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
            vga.vga_v_sync    <= (y_nxt >= VS_BEG && y_nxt <= VS_END) ? V_SYNC_POL : ~V_SYNC_POL;
            vga.line_start    <= ls_nxt;
            vga.frame_start   <= fs_nxt;
            vga.frame_count   <= vga.frame_count + 16'(fs_nxt);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboarded bench for three vga_timing_gen configurations
module tb_vga_timing_gen;

    typedef struct packed {
        logic        ce;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        de;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   t = 0;
    int   fb2 = 0;
    int   checks = 0;
    int   errors = 0;
    obs_t q0[$];
    obs_t q1[$];
    obs_t q2[$];
    obs_t o0;
    obs_t o1;
    obs_t o2;

    always #5 clk = ~clk;

    vga_timing_if v0();
    vga_timing_if v1();
    vga_timing_if v2();

    vga_timing_gen d0 (.clk(clk), .reset(reset), .vga(v0));
    vga_timing_gen #(.PIX_DIV(1), .H_SYNC_POL(1'b1)) d1 (.clk(clk), .reset(reset), .vga(v1));
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .V_SYNC_POL(1'b1)
    ) d2 (.clk(clk), .reset(reset), .vga(v2));

    assign o0 = {v0.pix_ce, v0.CounterX, v0.CounterY, v0.inDisplayArea, v0.vga_h_sync,
                 v0.vga_v_sync, v0.line_start, v0.frame_start, v0.frame_count};
    assign o1 = {v1.pix_ce, v1.CounterX, v1.CounterY, v1.inDisplayArea, v1.vga_h_sync,
                 v1.vga_v_sync, v1.line_start, v1.frame_start, v1.frame_count};
    assign o2 = {v2.pix_ce, v2.CounterX, v2.CounterY, v2.inDisplayArea, v2.vga_h_sync,
                 v2.vga_v_sync, v2.line_start, v2.frame_start, v2.frame_count};

    // closed-form raster position after tt non-reset clk edges
    function automatic obs_t model(int tt, int pd, int ha, int hf, int hw, int hb,
                                   int va, int vf, int vw, int vb, bit hp, bit vp, int fbase);
        int ht = ha + hf + hw + hb;
        int vt = va + vf + vw + vb;
        int p = tt / pd;
        int x;
        int y;
        int fr;
        obs_t o;
        if (p == 0) begin
            x = ht - 1;
            y = vt - 1;
            fr = 0;
        end else begin
            x = (p - 1) % ht;
            y = ((p - 1) / ht) % vt;
            fr = (p - 1) / (ht * vt) + 1;
        end
        o.ce = tt > 0 && tt % pd == pd - 1;
        o.x  = 10'(x);
        o.y  = 10'(y);
        o.de = x < ha && y < va;
        o.hs = (x >= ha + hf && x < ha + hf + hw) ? hp : !hp;
        o.vs = (y >= va + vf && y < va + vf + vw) ? vp : !vp;
        o.ls = p > 0 && tt % pd == 0 && x == 0;
        o.fs = o.ls && y == 0;
        o.fc = 16'(fr + fbase);
        return o;
    endfunction

    function automatic obs_t m0(int tt);
        return model(tt, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 0);
    endfunction

    function automatic obs_t m1(int tt);
        return model(tt, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b0, 0);
    endfunction

    function automatic obs_t m2(int tt, int fb);
        return model(tt, 2, 16, 4, 8, 4, 12, 2, 2, 3, 1'b0, 1'b1, fb);
    endfunction

    always @(posedge clk) begin
        q0.push_back(m0(reset ? 0 : t + 1));
        q1.push_back(m1(reset ? 0 : t + 1));
        q2.push_back(m2(reset ? 0 : t + 1, fb2));
        t <= reset ? 0 : t + 1;
    end

    always @(negedge clk) begin
        if (q0.size() > 0) begin
            checks++;
            if (o0 !== q0[0]) begin
                errors++;
                $display("FAIL sb_d0 t=%0d got %h want %h", t, o0, q0[0]);
            end
            q0.delete(0);
        end
        if (q1.size() > 0) begin
            checks++;
            if (o1 !== q1[0]) begin
                errors++;
                $display("FAIL sb_d1 t=%0d got %h want %h", t, o1, q1[0]);
            end
            q1.delete(0);
        end
        if (q2.size() > 0) begin
            checks++;
            if (o2 !== q2[0]) begin
                errors++;
                $display("FAIL sb_d2 t=%0d got %h want %h", t, o2, q2[0]);
            end
            q2.delete(0);
        end
    end

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (v0.CounterX !== 10'd799 || v0.CounterY !== 10'd524) begin
            errors++;
            $display("FAIL reset_xy got %0d/%0d want 799/524", v0.CounterX, v0.CounterY);
        end
        checks++;
        if ({v0.pix_ce, v0.inDisplayArea, v0.vga_h_sync, v0.vga_v_sync, v0.line_start, v0.frame_start} !== 6'b001100) begin
            errors++;
            $display("FAIL reset_flags got %b want 001100",
                     {v0.pix_ce, v0.inDisplayArea, v0.vga_h_sync, v0.vga_v_sync, v0.line_start, v0.frame_start});
        end
        checks++;
        if (v0.frame_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_fc got %0d want 0", v0.frame_count);
        end
        checks++;
        if (v1.vga_h_sync !== 1'b0 || v2.vga_v_sync !== 1'b0) begin
            errors++;
            $display("FAIL reset_pol got %b%b want 00", v1.vga_h_sync, v2.vga_v_sync);
        end
    endtask

    task automatic test_first_advance;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (v0.pix_ce !== 1'b1 || v0.CounterX !== 10'd799) begin
            errors++;
            $display("FAIL first_ce got ce=%b x=%0d want ce=1 x=799", v0.pix_ce, v0.CounterX);
        end
        checks++;
        if (v1.CounterX !== 10'd0 || v1.frame_start !== 1'b1 || v1.pix_ce !== 1'b1) begin
            errors++;
            $display("FAIL first_div1 got x=%0d fs=%b ce=%b want x=0 fs=1 ce=1", v1.CounterX, v1.frame_start, v1.pix_ce);
        end
        @(negedge clk);
        checks++;
        if (v0.CounterX !== 10'd0 || v0.CounterY !== 10'd0) begin
            errors++;
            $display("FAIL first_xy got %0d/%0d want 0/0", v0.CounterX, v0.CounterY);
        end
        checks++;
        if ({v0.line_start, v0.frame_start, v0.inDisplayArea} !== 3'b111 || v0.frame_count !== 16'd1) begin
            errors++;
            $display("FAIL first_strobes got ls=%b fs=%b de=%b fc=%0d want 1 1 1 1",
                     v0.line_start, v0.frame_start, v0.inDisplayArea, v0.frame_count);
        end
        @(negedge clk);
        checks++;
        if (v0.line_start !== 1'b0 || v0.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL first_pulse_len got ls=%b fs=%b want 0 0", v0.line_start, v0.frame_start);
        end
    endtask

    task automatic test_line;
        int n = 0;
        int hs_lo = 0;
        int hs_first = -1;
        int hs_last = -1;
        int de_fall = -1;
        while (!v0.line_start && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 4000) begin
            errors++;
            $display("FAIL line_wait timeout got %0d clks want <4000", n);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!v0.vga_h_sync) begin
                hs_lo++;
                if (hs_first < 0) hs_first = int'(v0.CounterX);
                hs_last = int'(v0.CounterX);
            end
            if (!v0.inDisplayArea && de_fall < 0) de_fall = int'(v0.CounterX);
        end while (!v0.line_start && n < 4000);
        checks++;
        if (n != 1600) begin
            errors++;
            $display("FAIL line_period got %0d want 1600", n);
        end
        checks++;
        if (hs_lo != 192 || hs_first != 656 || hs_last != 751) begin
            errors++;
            $display("FAIL line_hsync got %0d clks x=%0d..%0d want 192 x=656..751", hs_lo, hs_first, hs_last);
        end
        checks++;
        if (de_fall != 640) begin
            errors++;
            $display("FAIL line_de_fall got %0d want 640", de_fall);
        end
        checks++;
        if (v0.CounterY !== 10'd2) begin
            errors++;
            $display("FAIL line_y got %0d want 2", v0.CounterY);
        end
    endtask

    task automatic test_frame;
        int n = 0;
        int vs_hi = 0;
        int vs_x = -1;
        int vs_y = -1;
        logic [15:0] fc_a;
        while (!v2.frame_start && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL frame_wait timeout got %0d clks want <3000", n);
        end
        fc_a = m2(t, fb2).fc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (v2.vga_v_sync) begin
                vs_hi++;
                if (vs_x < 0) begin
                    vs_x = int'(v2.CounterX);
                    vs_y = int'(v2.CounterY);
                end
            end
        end while (!v2.frame_start && n < 3000);
        checks++;
        if (n != 1216) begin
            errors++;
            $display("FAIL frame_period got %0d want 1216", n);
        end
        checks++;
        if (vs_hi != 128 || vs_x != 0 || vs_y != 14) begin
            errors++;
            $display("FAIL frame_vsync got %0d clks at %0d/%0d want 128 at 0/14", vs_hi, vs_x, vs_y);
        end
        checks++;
        if (v2.frame_count !== fc_a + 16'd1) begin
            errors++;
            $display("FAIL frame_count got %0d want %0d", v2.frame_count, fc_a + 16'd1);
        end
    endtask

    task automatic test_mid_reset;
        int n = 0;
        while (v0.CounterX !== 10'd300 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL midrst_wait timeout got %0d clks want <2000", n);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (v0.CounterX !== 10'd799 || v0.CounterY !== 10'd524 || v0.frame_count !== 16'd0) begin
            errors++;
            $display("FAIL midrst_xy got %0d/%0d fc=%0d want 799/524 fc=0", v0.CounterX, v0.CounterY, v0.frame_count);
        end
        checks++;
        if ({v0.vga_h_sync, v0.vga_v_sync, v0.inDisplayArea, v0.pix_ce} !== 4'b1100) begin
            errors++;
            $display("FAIL midrst_flags got %b want 1100", {v0.vga_h_sync, v0.vga_v_sync, v0.inDisplayArea, v0.pix_ce});
        end
        repeat (2) @(negedge clk);
        checks++;
        if (v0.CounterX !== 10'd0 || v0.frame_start !== 1'b1 || v0.frame_count !== 16'd1) begin
            errors++;
            $display("FAIL midrst_restart got x=%0d fs=%b fc=%0d want x=0 fs=1 fc=1", v0.CounterX, v0.frame_start, v0.frame_count);
        end
    endtask

    task automatic test_pixdiv1;
        int n = 0;
        int ce_lo = 0;
        int hs_hi = 0;
        int hs_first = -1;
        while (!v1.line_start && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL div1_wait timeout got %0d clks want <2000", n);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!v1.pix_ce) ce_lo++;
            if (v1.vga_h_sync) begin
                hs_hi++;
                if (hs_first < 0) hs_first = int'(v1.CounterX);
            end
        end while (!v1.line_start && n < 2000);
        checks++;
        if (n != 800 || ce_lo != 0) begin
            errors++;
            $display("FAIL div1_period got %0d clks ce_low=%0d want 800 0", n, ce_lo);
        end
        checks++;
        if (hs_hi != 96 || hs_first != 656) begin
            errors++;
            $display("FAIL div1_hsync got %0d clks from x=%0d want 96 from 656", hs_hi, hs_first);
        end
    endtask

    task automatic test_wrap;
        int n = 0;
        int fs_cnt = 0;
        while (v2.CounterX !== 10'd5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL wrap_wait timeout got %0d clks want <200", n);
        end
        #1;
        fb2 = 65535 - int'(m2(t, 0).fc);
        force v2.frame_count = 16'hffff;
        #1;
        release v2.frame_count;
        n = 0;
        while (!v2.frame_start && n < 1300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1300 || v2.frame_count !== 16'd0) begin
            errors++;
            $display("FAIL wrap_fc got %0d after %0d clks want 0", v2.frame_count, n);
        end
        repeat (1215) begin
            @(negedge clk);
            if (v2.frame_start) fs_cnt++;
        end
        checks++;
        if (fs_cnt != 0 || v2.frame_count !== 16'd0) begin
            errors++;
            $display("FAIL wrap_once got extra_fs=%0d fc=%0d want 0 0", fs_cnt, v2.frame_count);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_advance();
        test_line();
        test_frame();
        test_mid_reset();
        test_pixdiv1();
        test_wrap();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
